// File: rtl/fpu_pkg.sv
// Shared FPU constants, field widths, divider state encoding and operand classification.
package fpu_pkg;

  localparam int unsigned FRAC_W = 52;
  localparam int unsigned EXP_W  = 11;
  localparam int unsigned SIGN_W = 1;

  localparam int          BIAS    = 1023;
  localparam logic [10:0] EXP_MAX = 11'h7FF;
  localparam logic [63:0] QNAN    = 64'h7FF8000000000000;

  typedef enum logic [1:0] {StIdle, StIter, StRound, StDone} div_state_e;

  typedef enum logic [1:0] {ClsNorm, ClsZero, ClsInf, ClsNan} fp_class_e;

  // Denormals report as zero: they are flushed on input.
  function automatic fp_class_e fp_classify(input logic [63:0] x);
    fp_class_e cls;
    cls = ClsNorm;
    if (x[62:52] == 11'd0) begin
      cls = ClsZero;
    end else if (x[62:52] == EXP_MAX) begin
      if (x[51:0] == 52'd0) cls = ClsInf;
      else                  cls = ClsNan;
    end
    return cls;
  endfunction

endpackage

// File: rtl/fp_round.sv
// Combinational normalize + round-to-nearest-even + overflow/underflow for a 56-bit raw
// quotient (1 integer + 55 fraction bits) and a biased, signed working exponent.
module fp_round
  import fpu_pkg::*;
(
  input  logic               [55:0] quo_i,
  input  logic                      rem_nz_i,
  input  logic signed        [12:0] exp_i,
  input  logic                      sign_i,
  output logic               [63:0] res_o
);

  logic        [52:0] man_pre;
  logic        [51:0] man_fin;
  logic        [53:0] man_inc;
  logic               g_bit, r_bit, s_bit, rnd;
  logic signed [12:0] e_pre, e_fin;

  always_comb begin
    if (quo_i[55]) begin
      man_pre = quo_i[55:3];
      g_bit   = quo_i[2];
      r_bit   = quo_i[1];
      s_bit   = rem_nz_i | quo_i[0];
      e_pre   = exp_i;
    end else begin
      man_pre = quo_i[54:2];
      g_bit   = quo_i[1];
      r_bit   = quo_i[0];
      s_bit   = rem_nz_i;
      e_pre   = exp_i - 13'sd1;
    end

    rnd     = g_bit & (man_pre[0] | r_bit | s_bit);
    man_inc = {1'b0, man_pre} + 54'(rnd);

    // A carry out only happens from all-ones, so the shifted fraction is zero.
    if (man_inc[53]) begin
      man_fin = man_inc[52:1];
      e_fin   = e_pre + 13'sd1;
    end else begin
      man_fin = man_inc[51:0];
      e_fin   = e_pre;
    end

    if (e_fin >= 13'sd2047) begin
      res_o = {sign_i, EXP_MAX, {FRAC_W{1'b0}}};
    end else if (e_fin <= 13'sd0) begin
      res_o = '0;
    end else begin
      res_o = {sign_i, e_fin[EXP_W-1:0], man_fin[FRAC_W-1:0]};
    end
  end

endmodule

// File: rtl/fp_div.sv
// IEEE-754 double divider: radix-2 restoring, one quotient bit per cycle, fixed latency.
// Special operands bypass the iteration and complete on the accept edge.
module fp_div
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] N1,
  input  logic [63:0] N2,
  output logic        busy,
  output logic        done,
  output logic [63:0] out
);

  div_state_e         state_q, state_d;
  logic        [5:0]  cnt_q, cnt_d;
  logic        [53:0] rem_q, rem_d;
  logic        [52:0] dvsr_q, dvsr_d;
  logic        [55:0] quo_q, quo_d;
  logic signed [12:0] exp_q, exp_d;
  logic [SIGN_W-1:0]  sign_q, sign_d;
  logic        [63:0] out_q, out_d;

  fp_class_e   cls1, cls2;
  logic        is_special;
  logic [63:0] special_res, round_res;
  logic        rem_ge, rem_nz;
  logic [53:0] rem_sub, rem_sel;

  assign cls1 = fp_classify(N1);
  assign cls2 = fp_classify(N2);

  always_comb begin
    is_special  = (cls1 != ClsNorm) || (cls2 != ClsNorm);
    special_res = '0;
    if (cls1 == ClsNan || cls2 == ClsNan || (cls1 == ClsZero && cls2 == ClsZero) ||
        (cls1 == ClsInf && cls2 == ClsInf)) begin
      special_res = QNAN;
    end else if (cls2 == ClsZero || cls1 == ClsInf) begin
      special_res = {N1[63] ^ N2[63], EXP_MAX, {FRAC_W{1'b0}}};
    end
  end

  assign rem_ge  = rem_q >= {1'b0, dvsr_q};
  assign rem_sub = rem_q - {1'b0, dvsr_q};
  assign rem_sel = rem_ge ? rem_sub : rem_q;
  assign rem_nz  = |rem_q;

  fp_round u_round (
    .quo_i    (quo_q),
    .rem_nz_i (rem_nz),
    .exp_i    (exp_q),
    .sign_i   (sign_q[0]),
    .res_o    (round_res)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvsr_d  = dvsr_q;
    quo_d   = quo_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    out_d   = out_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          sign_d = N1[63] ^ N2[63];
          if (is_special) begin
            out_d   = special_res;
            state_d = StDone;
          end else begin
            rem_d   = {2'b01, N1[FRAC_W-1:0]};
            dvsr_d  = {1'b1, N2[FRAC_W-1:0]};
            quo_d   = '0;
            cnt_d   = '0;
            exp_d   = $signed({2'b00, N1[FRAC_W +: EXP_W]}) -
                      $signed({2'b00, N2[FRAC_W +: EXP_W]}) + $signed(13'(BIAS));
            state_d = StIter;
          end
        end
      end
      StIter: begin
        // Remainder stays below twice the divisor, so the shift never loses a set bit.
        rem_d = rem_sel << 1;
        quo_d = {quo_q[54:0], rem_ge};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd55) begin
          cnt_d   = '0;
          state_d = StRound;
        end
      end
      StRound: begin
        out_d   = round_res;
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvsr_q  <= '0;
      quo_q   <= '0;
      exp_q   <= '0;
      sign_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvsr_q  <= dvsr_d;
      quo_q   <= quo_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      out_q   <= out_d;
    end
  end

  assign busy = (state_q == StIter) || (state_q == StRound);
  assign done = (state_q == StDone);
  assign out  = out_q;

endmodule

// File: tb/tb_fp_div.sv
// Self-checking bench for fp_div: directed corner cases, randomized operands against a
// real-arithmetic reference, start/reset interference.
module tb_fp_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] N1, N2;
  logic        busy, done;
  logic [63:0] out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp_div dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .N1    (N1),
    .N2    (N2),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  // Reference: classification rules for specials, IEEE double division otherwise,
  // with overflow to signed infinity and any subnormal/zero result flushed to +0.
  function automatic bit ref_special(input logic [63:0] a, input logic [63:0] b);
    return (a[62:52] == 11'h000) || (a[62:52] == 11'h7FF) ||
           (b[62:52] == 11'h000) || (b[62:52] == 11'h7FF);
  endfunction

  function automatic logic [63:0] ref_div(input logic [63:0] a, input logic [63:0] b);
    bit za, zb, ia, ib, na, nb;
    logic s;
    real q;
    logic [63:0] bits;
    za = (a[62:52] == 11'h000);
    zb = (b[62:52] == 11'h000);
    ia = (a[62:52] == 11'h7FF) && (a[51:0] == 52'd0);
    ib = (b[62:52] == 11'h7FF) && (b[51:0] == 52'd0);
    na = (a[62:52] == 11'h7FF) && (a[51:0] != 52'd0);
    nb = (b[62:52] == 11'h7FF) && (b[51:0] != 52'd0);
    s  = a[63] ^ b[63];
    if (na || nb || (za && zb) || (ia && ib)) return 64'h7FF8000000000000;
    if (zb || ia) return {s, 11'h7FF, 52'd0};
    if (za || ib) return 64'h0;
    q    = $bitstoreal(a) / $bitstoreal(b);
    bits = $realtobits(q);
    if (bits[62:52] == 11'h7FF) return {s, 11'h7FF, 52'd0};
    if (bits[62:52] == 11'h000) return 64'h0;
    return bits;
  endfunction

  function automatic logic [63:0] rnd_op();
    logic [63:0] m;
    logic [10:0] e;
    int k;
    m = {$urandom, $urandom};
    k = $urandom_range(0, 11);
    case (k)
      0:       e = 11'h000;
      1:       begin e = 11'h7FF; m[51:0] = 52'd0; end
      2:       begin e = 11'h7FF; m[51] = 1'b1; end
      3, 4, 5: e = 11'($urandom_range(1, 2046));
      default: e = 11'($urandom_range(900, 1150));
    endcase
    return {m[63], e, m[51:0]};
  endfunction

  // lat = clock edges between the accept edge and the first cycle with done high.
  task automatic run_div(input logic [63:0] a, input logic [63:0] b, output logic [63:0] res,
                         output int lat, output int busy_cnt, output bit timeout);
    @(negedge clk);
    N1 = a; N2 = b; start = 1'b1;
    @(posedge clk);
    lat = -1; busy_cnt = 0; timeout = 1'b1; res = 'x;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        lat = i; res = out; timeout = 1'b0;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; N1 = '0; N2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== 64'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b out=%h, want busy=0 done=0 out=0",
               busy, done, out);
    end
    rst = 1'b0;
  endtask

  logic [63:0] d_a [10] = '{64'h4018000000000000, 64'h3FF0000000000000, 64'h3FF0000000000000,
                            64'h3FF0000000000000, 64'hBFF0000000000000, 64'h0000000000000000,
                            64'h7FF0000000000000, 64'h7FEFFFFFFFFFFFFF, 64'h0010000000000000,
                            64'h3FF0000000000000};
  logic [63:0] d_b [10] = '{64'h4000000000000000, 64'h4008000000000000, 64'hBFF8000000000000,
                            64'h0000000000000000, 64'h0000000000000000, 64'h0000000000000000,
                            64'h7FF0000000000000, 64'h3FE0000000000000, 64'h4000000000000000,
                            64'h7FF0000000000001};
  logic [63:0] d_q [10] = '{64'h4008000000000000, 64'h3FD5555555555555, 64'hBFE5555555555555,
                            64'h7FF0000000000000, 64'hFFF0000000000000, 64'h7FF8000000000000,
                            64'h7FF8000000000000, 64'h7FF0000000000000, 64'h0000000000000000,
                            64'h7FF8000000000000};
  bit          d_sp [10] = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 1};

  task automatic test_directed();
    logic [63:0] res;
    int lat, bcnt, want_lat;
    bit to;
    for (int i = 0; i < 10; i++) begin
      run_div(d_a[i], d_b[i], res, lat, bcnt, to);
      // Normal: 56 ITER + 1 ROUND; special: done in the cycle right after accept.
      want_lat = d_sp[i] ? 0 : 57;
      checks++;
      if (to || res !== d_q[i]) begin
        errors++;
        $display("FAIL directed[%0d] result: got %h want %h (timeout=%0b)", i, res, d_q[i], to);
      end
      checks++;
      if (lat != want_lat || bcnt != want_lat) begin
        errors++;
        $display("FAIL directed[%0d] timing: lat=%0d busy=%0d want %0d/%0d",
                 i, lat, bcnt, want_lat, want_lat);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (out !== d_q[i] || done !== 1'b0) begin
        errors++;
        $display("FAIL directed[%0d] hold: out=%h done=%b want out=%h done=0",
                 i, out, done, d_q[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] a, b, res, want;
    int lat, bcnt, want_lat;
    bit to;
    for (int i = 0; i < 60; i++) begin
      a = rnd_op();
      b = rnd_op();
      want     = ref_div(a, b);
      want_lat = ref_special(a, b) ? 0 : 57;
      run_div(a, b, res, lat, bcnt, to);
      checks++;
      if (to || res !== want || lat != want_lat) begin
        errors++;
        $display("FAIL random[%0d] %h/%h: got %h lat=%0d want %h lat=%0d",
                 i, a, b, res, lat, want, want_lat);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    logic [63:0] res;
    @(negedge clk);
    N1 = 64'h4018000000000000; N2 = 64'h4000000000000000; start = 1'b1;
    @(posedge clk);
    lat = -1; res = 'x;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      start = (i == 10);
      if (i == 10) begin
        N1 = 64'h3FF0000000000000; N2 = 64'h4008000000000000;
      end
      if (done) begin
        lat = i; res = out;
        break;
      end
    end
    checks++;
    if (res !== 64'h4008000000000000 || lat != 57) begin
      errors++;
      $display("FAIL ignore_start: got %h lat=%0d want 4008000000000000 lat=57", res, lat);
    end
  endtask

  task automatic test_reset_midflight();
    logic [63:0] res;
    int lat, bcnt;
    bit to;
    @(negedge clk);
    N1 = 64'h3FF0000000000000; N2 = 64'hBFF8000000000000; start = 1'b1;
    @(posedge clk);
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== 64'h0) begin
      errors++;
      $display("FAIL reset_midflight: busy=%b done=%b out=%h want 0/0/0", busy, done, out);
    end
    rst = 1'b0;
    run_div(64'h3FF0000000000000, 64'h4008000000000000, res, lat, bcnt, to);
    checks++;
    if (to || res !== 64'h3FD5555555555555 || lat != 57) begin
      errors++;
      $display("FAIL after_reset: got %h lat=%0d want 3FD5555555555555 lat=57", res, lat);
    end
  endtask

  task automatic test_start_with_rst();
    @(negedge clk);
    rst = 1'b1; start = 1'b1; N1 = 64'h3FF0000000000000; N2 = 64'h0;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== 64'h0) begin
      errors++;
      $display("FAIL start_with_rst: busy=%b done=%b out=%h want 0/0/0", busy, done, out);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_with_rst_idle: busy=%b done=%b want 0/0", busy, done);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_midflight();
    test_start_with_rst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
